// File: rtl/video_frame_normalizer_if.sv
// Avalon-ST sink and source signals of the video frame normalizer.
// The normalizer uses the slave modport. A driver or monitor uses the master modport.
interface video_frame_normalizer_if;
    localparam int unsigned DW = 30;

    logic [DW-1:0] data_in;
    logic          startofpacket_in;
    logic          endofpacket_in;
    logic          valid_in;
    logic          ready_out;
    logic [DW-1:0] data_out;
    logic          startofpacket_out;
    logic          endofpacket_out;
    logic          valid_out;
    logic          ready_in;

    modport slave (
        input  data_in, startofpacket_in, endofpacket_in, valid_in, ready_in,
        output ready_out, data_out, startofpacket_out, endofpacket_out, valid_out
    );

    modport master (
        output data_in, startofpacket_in, endofpacket_in, valid_in, ready_in,
        input  ready_out, data_out, startofpacket_out, endofpacket_out, valid_out
    );
endinterface

// File: rtl/video_frame_normalizer.sv
// Forces every forwarded video packet to exactly WIDTH*HEIGHT pixels.
// Control packets are dropped, short frames are padded black and long frames are truncated.
module video_frame_normalizer #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic                     clk,
    input  logic                     reset,
    video_frame_normalizer_if.slave  s,
    output logic [7:0]               short_frames,
    output logic [7:0]               long_frames,
    output logic [7:0]               dropped_packets
);
    localparam int unsigned N  = WIDTH * HEIGHT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, HDR, PIX, PAD, SKIP, DRAIN} state_t;

    state_t          r_state, w_next_state;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [7:0]      r_short, r_long, r_drop;
    logic            w_short_inc, w_long_inc, w_drop_inc;
    logic            w_last;

    assign w_last = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_short <= '0;
            r_long  <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_short_inc) r_short <= r_short + 8'd1;
            if (w_long_inc)  r_long  <= r_long + 8'd1;
            if (w_drop_inc)  r_drop  <= r_drop + 8'd1;
        end
    end

    // Next state, counter updates and handshake outputs. PIX is a combinational pass-through.
    always_comb begin
        w_next_state        = r_state;
        w_cnt_next          = r_cnt;
        w_short_inc         = 1'b0;
        w_long_inc          = 1'b0;
        w_drop_inc          = 1'b0;
        s.ready_out         = 1'b0;
        s.valid_out         = 1'b0;
        s.data_out          = '0;
        s.startofpacket_out = 1'b0;
        s.endofpacket_out   = 1'b0;

        case (r_state)
            IDLE: begin
                s.ready_out = 1'b1;
                if (s.valid_in && s.startofpacket_in) begin
                    if (s.data_in[3:0] == 4'd0) begin
                        w_next_state = HDR;
                    end else begin
                        w_drop_inc   = 1'b1;
                        w_next_state = s.endofpacket_in ? IDLE : SKIP;
                    end
                end
            end
            HDR: begin
                s.valid_out         = 1'b1;
                s.startofpacket_out = 1'b1;
                if (s.ready_in) begin
                    w_cnt_next   = '0;
                    w_next_state = PIX;
                end
            end
            PIX: begin
                s.valid_out       = s.valid_in & ~s.startofpacket_in;
                s.ready_out       = s.ready_in & ~s.startofpacket_in;
                s.data_out        = s.data_in;
                s.endofpacket_out = w_last;
                // An early SOP stays on the input until padding completes.
                if (s.valid_in && s.startofpacket_in) begin
                    w_short_inc  = 1'b1;
                    w_next_state = PAD;
                end else if (s.valid_in && s.ready_in) begin
                    if (w_last) begin
                        if (s.endofpacket_in) begin
                            w_next_state = IDLE;
                        end else begin
                            w_long_inc   = 1'b1;
                            w_next_state = DRAIN;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                        if (s.endofpacket_in) begin
                            w_short_inc  = 1'b1;
                            w_next_state = PAD;
                        end
                    end
                end
            end
            PAD: begin
                s.valid_out       = 1'b1;
                s.endofpacket_out = w_last;
                if (s.ready_in) begin
                    w_cnt_next = r_cnt + CW'(1);
                    if (w_last) w_next_state = IDLE;
                end
            end
            SKIP: begin
                s.ready_out = 1'b1;
                if (s.valid_in && s.endofpacket_in) w_next_state = IDLE;
            end
            DRAIN: begin
                s.ready_out = ~s.startofpacket_in;
                if (s.valid_in && (s.startofpacket_in || s.endofpacket_in)) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign short_frames    = r_short;
    assign long_frames     = r_long;
    assign dropped_packets = r_drop;
endmodule

// File: doc/video_frame_normalizer.md
# video_frame_normalizer

Avalon-ST video stage placed directly upstream of the 3x3 convolution filter stage. It guarantees that the filter only ever sees video packets with exactly WIDTH*HEIGHT pixels. It removes non-video (control) packets, pads short frames with black pixels, and truncates long frames. It also counts every correction it makes for debug readout.

## Interface
Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, lines per frame; N = WIDTH*HEIGHT pixels per frame; pixel counter width CW = $clog2(N)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- data_in  input  30  Avalon-ST sink data, RGB 10:10:10; on a SOP beat, bits [3:0] hold the packet type
- startofpacket_in  input  1  sink SOP
- endofpacket_in  input  1  sink EOP
- valid_in  input  1  sink valid
- ready_out  output  1  sink ready
- data_out  output  30  source data
- startofpacket_out  output  1  source SOP
- endofpacket_out  output  1  source EOP
- valid_out  output  1  source valid
- ready_in  input  1  source ready from the convolution filter
- short_frames  output  8  count of padded frames, wraps at 255
- long_frames  output  8  count of truncated frames, wraps at 255
- dropped_packets  output  8  count of discarded control packets, wraps at 255

## Operation
- Beat transfer definitions:
  - Input beat accepted = valid_in & ready_out.
  - Output beat accepted = valid_out & ready_in.
- FSM states are IDLE, HDR, PIX, PAD, SKIP and DRAIN. The pixel counter `cnt` (CW bits) counts output pixels in the current frame.
- IDLE:
  - ready_out=1, valid_out=0.
  - An accepted beat without SOP is discarded.
  - Accepted SOP beat with data_in[3:0]==0 → HDR.
  - Accepted SOP beat with data_in[3:0]!=0: dropped_packets+1, then → SKIP. If that same beat also has EOP, stay in IDLE instead.
- HDR:
  - ready_out=0, valid_out=1, data_out=30'd0, startofpacket_out=1, endofpacket_out=0.
  - On output accept: cnt←0, → PIX.
- PIX (combinational pass-through):
  - valid_out=valid_in & ~startofpacket_in.
  - ready_out=ready_in & ~startofpacket_in.
  - data_out=data_in, startofpacket_out=0, endofpacket_out=(cnt==N-1).
  - A SOP on the input while in PIX is not consumed: short_frames+1, → PAD, cnt unchanged.
  - Accepted beat with cnt==N-1: if endofpacket_in → IDLE; otherwise long_frames+1 and → DRAIN.
  - Accepted beat with endofpacket_in and cnt<N-1: short_frames+1, cnt←cnt+1, → PAD.
  - Any other accepted beat: cnt←cnt+1.
- PAD:
  - ready_out=0, valid_out=1, data_out=0 (black), endofpacket_out=(cnt==N-1).
  - On each output accept: cnt+1.
  - Accepting the cnt==N-1 beat → IDLE.
- SKIP: ready_out=1, valid_out=0. Discard beats until an accepted EOP → IDLE.
- DRAIN:
  - ready_out=1, valid_out=0. Discard beats until an accepted EOP → IDLE.
  - A SOP beat arriving in DRAIN is not consumed: ready_out=0 for that beat, → IDLE, where it is accepted next cycle.
- Counters: 8-bit, wrap silently, cleared only by reset. Every emitted frame is exactly 1 header beat plus N pixel beats.

## Timing
- Reset (async assert, synchronous deassert assumed upstream):
  - State is IDLE, cnt=0, all three counters are 0.
  - Outputs during reset: valid_out=0, data_out=0, startofpacket_out=0, endofpacket_out=0, ready_out=1.
- Reset asserted mid-frame abandons the frame. The downstream stage sees a packet without EOP and is reset by the same signal.
- PIX latency is 0 cycles: data and valid flow combinationally, and ready_in reaches ready_out combinationally.
- HDR and PAD outputs are driven from registered state only. valid_out holds and data is stable until accepted (Avalon-ST source rule).
- Minimum gap between frames: 1 cycle (the IDLE accept of the next SOP), then the HDR beat.
- ready_in low in PIX stalls input and output together; no beat is lost or duplicated.
- The FSM advances on accepted beats only. valid_in without ready_out changes nothing.

## Test plan
WIDTH=4, HEIGHT=2 (N=8) for all scenarios.
- Nominal frame: type-0 header plus 8 pixels with EOP on the 8th → header plus 8 pixels out, identical data, EOP on pixel 7; all counters stay 0.
- Short frame: header plus 5 pixels, EOP on the 5th → 5 pixels passed, then 3 zero pixels, EOP on the last; short_frames=1.
- Long frame: header plus 11 pixels → 8 pixels out with EOP on the 8th; pixels 9–11 consumed with no output; long_frames=1.
- Control packet: SOP type 0xF plus 3 beats with EOP, then a nominal frame → only the video frame appears at the output; dropped_packets=1.
- Early SOP: a new type-0 header arrives after 3 pixels with no EOP → 5 black pads with EOP; then the new frame is emitted complete; short_frames=1.
- Backpressure plus reset: ready_in toggles every cycle during PIX → output sequence is identical to the nominal case. Asserting reset mid-PAD → valid_out=0 immediately and all counters read 0.
